// File: rtl/gauss_series_engine.sv
// Arithmetic-series summation engine: sum of n terms a + i*d, one term per clock, wrapping modulo 2^WIDTH.
// Optional carry tracking is enabled by defining OVERFLOW_DETECT_EN; otherwise overflow is tied low.
module gauss_series_engine #(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 preset_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     first,
  input  logic [WIDTH-1:0]     step,
  input  logic [CNT_WIDTH-1:0] count,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     result,
  output logic                 overflow
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]     term_q, term_d;
  logic [WIDTH-1:0]     inc_q, inc_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
`ifdef OVERFLOW_DETECT_EN
  logic                 ovf_q, ovf_d;
  logic [WIDTH:0]       sum_w;
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    term_d  = term_q;
    inc_d   = inc_q;
    cnt_d   = cnt_q;
`ifdef OVERFLOW_DETECT_EN
    ovf_d   = ovf_q;
    sum_w   = {1'b0, acc_q} + {1'b0, term_q};
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          acc_d   = '0;
          term_d  = first;
          inc_d   = step;
          cnt_d   = count;
          state_d = ACCUM;
`ifdef OVERFLOW_DETECT_EN
          ovf_d   = 1'b0;
`endif
        end
      end
      ACCUM: begin
        if (cnt_q != '0) begin
`ifdef OVERFLOW_DETECT_EN
          acc_d = sum_w[WIDTH-1:0];
          ovf_d = ovf_q | sum_w[WIDTH];
`else
          acc_d = acc_q + term_q;
`endif
          term_d = term_q + inc_q;
          cnt_d  = cnt_q - 1'b1;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Status flags are registered from the next state so they align with state_q.
    busy_d = (state_d == ACCUM);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge preset_n) begin
    if (!preset_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      term_q  <= '0;
      inc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef OVERFLOW_DETECT_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      term_q  <= term_d;
      inc_q   <= inc_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef OVERFLOW_DETECT_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = acc_q;
`ifdef OVERFLOW_DETECT_EN
  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

endmodule
